// File: rtl/w3d_mmio_avalon_bridge_if.sv
// w3d_mmio_avalon_bridge_if: reduced AXI-Lite slave side plus Avalon-MM master side of the MMIO bridge.
// The slave modport is the bridge's view; the master modport is the view of whatever drives and answers it.
interface w3d_mmio_avalon_bridge_if;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic        s_bvalid, s_bready;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [31:0] avl_address;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic        timeout_pulse;
  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready, s_arvalid, s_araddr, s_rready,
           avl_readdata, avl_waitrequest,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata,
           avl_address, avl_read, avl_write, avl_writedata, avl_byteenable, timeout_pulse
  );
  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_bready, s_arvalid, s_araddr, s_rready,
           avl_readdata, avl_waitrequest,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata,
           avl_address, avl_read, avl_write, avl_writedata, avl_byteenable, timeout_pulse
  );
endinterface

// File: rtl/w3d_mmio_avalon_bridge.sv
// w3d_mmio_avalon_bridge: reduced AXI-Lite slave to single-outstanding Avalon-MM master, read/write alternating.
// Define W3D_MMIO_TIMEOUT_EN to force-complete transfers stalled by waitrequest for TIMEOUT_CYCLES cycles.
module w3d_mmio_avalon_bridge #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input logic clk,
  input logic rst_n,
  w3d_mmio_avalon_bridge_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_BRESP, S_READ, S_RRESP} state_t;
  state_t      r_state, w_next;
  logic        r_aw_held, r_w_held, r_read_pref;
  logic [31:0] r_aw_addr, r_w_data, r_avl_address, r_avl_writedata, r_rdata;
  logic        r_avl_read, r_avl_write, r_bvalid, r_rvalid, r_to_pulse;
  logic        w_write_pending, w_ar_fire, w_aw_fire, w_w_fire, w_wr_done, w_to;
  assign w_write_pending     = r_aw_held && r_w_held;
  assign bus.s_awready       = !r_aw_held;
  assign bus.s_wready        = !r_w_held;
  assign bus.s_arready       = (r_state == S_IDLE) && !(w_write_pending && !r_read_pref);
  assign w_ar_fire           = bus.s_arvalid && bus.s_arready;
  assign w_aw_fire           = bus.s_awvalid && !r_aw_held;
  assign w_w_fire            = bus.s_wvalid && !r_w_held;
  assign w_wr_done           = (r_state == S_WRITE) && (w_next == S_BRESP);
  assign bus.s_bvalid        = r_bvalid;
  assign bus.s_rvalid        = r_rvalid;
  assign bus.s_rdata         = r_rdata;
  assign bus.avl_address     = r_avl_address;
  assign bus.avl_read        = r_avl_read;
  assign bus.avl_write       = r_avl_write;
  assign bus.avl_writedata   = r_avl_writedata;
  assign bus.avl_byteenable  = 4'hF;
  assign bus.timeout_pulse   = r_to_pulse;
`ifdef W3D_MMIO_TIMEOUT_EN
  logic [31:0] r_cnt;
  // Counts cycles spent in the current command state; any state change restarts it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (w_next == r_state && (r_state == S_WRITE || r_state == S_READ)) ? r_cnt + 32'd1 : '0;
  assign w_to = (r_state == S_WRITE || r_state == S_READ) && bus.avl_waitrequest &&
                r_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = w_ar_fire ? S_READ : w_write_pending ? S_WRITE : S_IDLE;
      S_WRITE: w_next = (!bus.avl_waitrequest || w_to) ? S_BRESP : S_WRITE;
      S_BRESP: w_next = bus.s_bready ? S_IDLE : S_BRESP;
      S_READ:  w_next = (!bus.avl_waitrequest || w_to) ? S_RRESP : S_READ;
      S_RRESP: w_next = bus.s_rready ? S_IDLE : S_RRESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_aw_held       <= 1'b0;
      r_w_held        <= 1'b0;
      r_read_pref     <= 1'b0;
      r_aw_addr       <= '0;
      r_w_data        <= '0;
      r_avl_address   <= '0;
      r_avl_writedata <= '0;
      r_rdata         <= '0;
      r_avl_read      <= 1'b0;
      r_avl_write     <= 1'b0;
      r_bvalid        <= 1'b0;
      r_rvalid        <= 1'b0;
      r_to_pulse      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= bus.s_awaddr;
      end else if (w_wr_done) r_aw_held <= 1'b0;
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_w_data <= bus.s_wdata;
      end else if (w_wr_done) r_w_held <= 1'b0;
      if (w_wr_done) r_read_pref <= 1'b1;
      else if (w_ar_fire) r_read_pref <= 1'b0;
      // Command strobes and responses are registered copies of the next state.
      r_avl_write <= w_next == S_WRITE;
      r_avl_read  <= w_next == S_READ;
      r_bvalid    <= w_next == S_BRESP;
      r_rvalid    <= w_next == S_RRESP;
      r_to_pulse  <= w_to;
      if (r_state == S_IDLE && w_next == S_WRITE) begin
        r_avl_address   <= r_aw_addr;
        r_avl_writedata <= r_w_data;
      end
      if (w_ar_fire) r_avl_address <= bus.s_araddr;
      if (r_state == S_READ && w_next == S_RRESP) r_rdata <= w_to ? TIMEOUT_DATA : bus.avl_readdata;
    end
endmodule
